// File: rtl/m_regfile_pkg.sv
// Shared core package: register index type, sizes and the decoded bundle.
// Imported by the register file, its scoreboard and its bus interface.
package m_regfile_pkg;

   localparam int NREGS = 32;
   localparam int WIDTH = 32;

   typedef logic [4:0]       t_ridx;
   typedef logic [WIDTH-1:0] t_word;

   typedef struct packed {
      t_ridx rd;
      t_ridx rs;
      t_ridx rq;
      logic  rd_valid;
      t_word imm;
   } s_decoded;

endpackage

// File: rtl/m_regfile_if.sv
// Register file bus: read ports, reservation and writeback handshakes.
// master = decoder/writeback side, slave = the register file.
interface m_regfile_if
   import m_regfile_pkg::*;
#(
   parameter int WIDTH = m_regfile_pkg::WIDTH
);
   t_ridx            rs_sel;
   logic [WIDTH-1:0] rs_out;
   logic             rs_busy;
   t_ridx            rq_sel;
   logic [WIDTH-1:0] rq_out;
   logic             rq_busy;
   logic             rsv_valid;
   t_ridx            rsv_sel;
   logic             rsv_ready;
   logic             wr_valid;
   t_ridx            wr_sel;
   logic [WIDTH-1:0] wr_data;
   logic             wr_err;
   logic             flush;

   modport master (
      output rs_sel, rq_sel, rsv_valid, rsv_sel,
      output wr_valid, wr_sel, wr_data, flush,
      input  rs_out, rq_out, rs_busy, rq_busy,
      input  rsv_ready, wr_err
   );

   modport slave (
      input  rs_sel, rq_sel, rsv_valid, rsv_sel,
      input  wr_valid, wr_sel, wr_data, flush,
      output rs_out, rq_out, rs_busy, rq_busy,
      output rsv_ready, wr_err
   );
endinterface

// File: rtl/m_regfile_scoreboard.sv
// Pending-write scoreboard: busy vector, reservation accept, stray-write flag.
// r0 is never reserved; flush drops every pending reservation.
module m_scoreboard
   import m_regfile_pkg::*;
#(
   parameter int NREGS = m_regfile_pkg::NREGS
) (
   input  logic  clk,
   input  logic  rst,
   input  t_ridx i_rs_sel,
   input  t_ridx i_rq_sel,
   input  logic  i_rsv_valid,
   input  t_ridx i_rsv_sel,
   input  logic  i_wr_valid,
   input  t_ridx i_wr_sel,
   input  logic  i_flush,
   output logic  o_rs_busy,
   output logic  o_rq_busy,
   output logic  o_rsv_ready,
   output logic  o_wr_err
);
   logic [NREGS-1:0] r_busy;
   logic [NREGS-1:0] w_busy_nxt;
   logic             r_wr_err;
   logic             w_err_nxt;

   assign o_rsv_ready = i_rsv_valid & ~r_busy[i_rsv_sel] & ~i_flush;
   assign o_rs_busy   = r_busy[i_rs_sel]
                      & ~(i_wr_valid & (i_wr_sel == i_rs_sel));
   assign o_rq_busy   = r_busy[i_rq_sel]
                      & ~(i_wr_valid & (i_wr_sel == i_rq_sel));
   assign o_wr_err    = r_wr_err;

   // Writes to r0 are discarded, so they are never reported as stray.
   assign w_err_nxt = i_wr_valid & (i_wr_sel != '0)
                    & ~r_busy[i_wr_sel] & ~i_flush;

   always_comb begin
      w_busy_nxt = r_busy;
      if (i_flush) begin
         w_busy_nxt = '0;
      end else begin
         if (i_wr_valid)
            w_busy_nxt[i_wr_sel] = 1'b0;
         if (o_rsv_ready && (i_rsv_sel != '0))
            w_busy_nxt[i_rsv_sel] = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_busy   <= '0;
         r_wr_err <= 1'b0;
      end else begin
         r_busy   <= w_busy_nxt;
         r_wr_err <= w_err_nxt;
      end
   end
endmodule

// File: rtl/m_regfile.sv
// Architectural register file: two bypassed combinational read ports,
// one writeback port, and a scoreboard tracking reserved destinations.
module m_regfile
   import m_regfile_pkg::*;
#(
   parameter int NREGS = m_regfile_pkg::NREGS,
   parameter int WIDTH = m_regfile_pkg::WIDTH
) (
   input logic         clk,
   input logic         rst,
   m_regfile_if.slave  bus
);
   logic [WIDTH-1:0] r_regs [NREGS];
   logic [WIDTH-1:0] w_rs_data;
   logic [WIDTH-1:0] w_rq_data;
   logic             w_rs_byp;
   logic             w_rq_byp;

   assign w_rs_byp = bus.wr_valid & (bus.wr_sel == bus.rs_sel);
   assign w_rq_byp = bus.wr_valid & (bus.wr_sel == bus.rq_sel);

   always_comb begin
      w_rs_data = r_regs[bus.rs_sel];
      w_rq_data = r_regs[bus.rq_sel];
      if (w_rs_byp)
         w_rs_data = bus.wr_data;
      if (w_rq_byp)
         w_rq_data = bus.wr_data;
      if (bus.rs_sel == '0)
         w_rs_data = '0;
      if (bus.rq_sel == '0)
         w_rq_data = '0;
   end

   assign bus.rs_out = w_rs_data;
   assign bus.rq_out = w_rq_data;

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NREGS; i++)
            r_regs[i] <= '0;
      end else if (bus.wr_valid && (bus.wr_sel != '0)) begin
         r_regs[bus.wr_sel] <= bus.wr_data;
      end
   end

   m_scoreboard #(
      .NREGS (NREGS)
   ) u_sb (
      .clk         (clk),
      .rst         (rst),
      .i_rs_sel    (bus.rs_sel),
      .i_rq_sel    (bus.rq_sel),
      .i_rsv_valid (bus.rsv_valid),
      .i_rsv_sel   (bus.rsv_sel),
      .i_wr_valid  (bus.wr_valid),
      .i_wr_sel    (bus.wr_sel),
      .i_flush     (bus.flush),
      .o_rs_busy   (bus.rs_busy),
      .o_rq_busy   (bus.rq_busy),
      .o_rsv_ready (bus.rsv_ready),
      .o_wr_err    (bus.wr_err)
   );
endmodule

// File: tb/tb_m_regfile.sv
// Self-checking bench for m_regfile: directed scenarios then random traffic,
// every output compared against an array-based register/reservation model.
module tb_m_regfile;
   import m_regfile_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_cmp = 0;
   int   n_bad = 0;

   m_regfile_if bus ();

   m_regfile u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   logic [31:0] m_regs [32];
   bit   [31:0] m_busy;
   bit          m_err;
   bit          m_ok = 1'b0;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [31:0] exp_rd(input bit [4:0] sel);
      if (sel == 0) return 32'h0;
      if (bus.wr_valid && bus.wr_sel == sel) return bus.wr_data;
      return m_regs[sel];
   endfunction

   function automatic bit exp_busy(input bit [4:0] sel);
      if (bus.wr_valid && bus.wr_sel == sel) return 1'b0;
      return m_busy[sel];
   endfunction

   // Apply one cycle of inputs and check the combinational/registered view.
   task automatic drive(input bit r, input bit [4:0] rs, input bit [4:0] rq,
                        input bit rv, input bit [4:0] rsel,
                        input bit wv, input bit [4:0] ws,
                        input bit [31:0] wd, input bit fl);
      rst           = r;
      bus.rs_sel    = rs;
      bus.rq_sel    = rq;
      bus.rsv_valid = rv;
      bus.rsv_sel   = rsel;
      bus.wr_valid  = wv;
      bus.wr_sel    = ws;
      bus.wr_data   = wd;
      bus.flush     = fl;
      #1;
      if (m_ok) begin
         chk("rs_out", bus.rs_out, exp_rd(rs));
         chk("rq_out", bus.rq_out, exp_rd(rq));
         chk("rs_busy", 32'(bus.rs_busy), 32'(exp_busy(rs)));
         chk("rq_busy", 32'(bus.rq_busy), 32'(exp_busy(rq)));
         chk("rsv_ready", 32'(bus.rsv_ready),
             32'(rv && !m_busy[rsel] && !fl));
         chk("wr_err", 32'(bus.wr_err), 32'(m_err));
      end
   endtask

   task automatic tick();
      bit rdy;
      bit [4:0] ws;
      rdy = bus.rsv_valid && !m_busy[bus.rsv_sel] && !bus.flush;
      ws  = bus.wr_sel;
      @(posedge clk);
      if (rst) begin
         foreach (m_regs[i]) m_regs[i] = 32'h0;
         m_busy = '0;
         m_err  = 1'b0;
         m_ok   = 1'b1;
      end else begin
         m_err = bus.wr_valid && ws != 0 && !m_busy[ws] && !bus.flush;
         if (bus.wr_valid && ws != 0) m_regs[ws] = bus.wr_data;
         if (bus.flush) m_busy = '0;
         else begin
            if (bus.wr_valid) m_busy[ws] = 1'b0;
            if (rdy && bus.rsv_sel != 0) m_busy[bus.rsv_sel] = 1'b1;
         end
      end
      #1;
   endtask

   initial begin
      drive(1, 0, 0, 0, 0, 0, 0, 0, 0); tick();
      drive(1, 0, 0, 0, 0, 0, 0, 0, 0); tick();

      drive(0, 1, 2, 1, 8, 0, 0, 0, 0);
      chk("rst_rs_out", bus.rs_out, 32'h0);
      chk("rst_rs_busy", 32'(bus.rs_busy), 32'h0);
      chk("rst_rsv_ready", 32'(bus.rsv_ready), 32'h1);
      drive(0, 0, 0, 0, 0, 1, 5, 32'haaaaaaaa, 0); tick();
      drive(0, 5, 0, 0, 0, 0, 0, 0, 0);
      chk("r5_read", bus.rs_out, 32'haaaaaaaa);
      chk("r0_read", bus.rq_out, 32'h0);
      tick();

      drive(0, 0, 7, 0, 0, 1, 7, 32'hffffffff, 0);
      chk("r7_bypass", bus.rq_out, 32'hffffffff);
      tick();

      drive(0, 0, 0, 1, 3, 0, 0, 0, 0);
      chk("rsv3", 32'(bus.rsv_ready), 32'h1);
      tick();
      drive(0, 3, 0, 1, 3, 0, 0, 0, 0);
      chk("r3_busy", 32'(bus.rs_busy), 32'h1);
      chk("rsv3_waw", 32'(bus.rsv_ready), 32'h0);
      tick();
      drive(0, 3, 0, 0, 0, 1, 3, 32'h33, 0); tick();
      drive(0, 3, 0, 0, 0, 0, 0, 0, 0);
      chk("r3_cleared", 32'(bus.rs_busy), 32'h0);
      chk("r3_no_err", 32'(bus.wr_err), 32'h0);
      tick();

      drive(0, 0, 0, 1, 4, 0, 0, 0, 0); tick();
      drive(0, 0, 0, 1, 4, 1, 4, 32'h44, 0);
      chk("rsv4_wr_same", 32'(bus.rsv_ready), 32'h0);
      tick();
      drive(0, 4, 0, 1, 4, 0, 0, 0, 0);
      chk("r4_free", 32'(bus.rs_busy), 32'h0);
      chk("rsv4_retry", 32'(bus.rsv_ready), 32'h1);
      tick();
      drive(0, 0, 0, 0, 0, 1, 4, 32'h45, 0); tick();

      drive(0, 0, 0, 0, 0, 1, 9, 32'h5a5a5a5a, 0); tick();
      drive(0, 9, 0, 0, 0, 0, 0, 0, 0);
      chk("r9_err", 32'(bus.wr_err), 32'h1);
      chk("r9_data", bus.rs_out, 32'h5a5a5a5a);
      tick();
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
      chk("r9_err_once", 32'(bus.wr_err), 32'h0);
      tick();
      drive(0, 0, 0, 0, 0, 1, 0, 32'h1234, 0);
      chk("r0_bypass", bus.rs_out, 32'h0);
      tick();
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
      chk("r0_no_err", 32'(bus.wr_err), 32'h0);
      tick();

      drive(0, 0, 0, 1, 1, 0, 0, 0, 0); tick();
      drive(0, 0, 0, 1, 2, 0, 0, 0, 0); tick();
      drive(0, 1, 2, 1, 6, 0, 0, 0, 1);
      chk("flush_rsv", 32'(bus.rsv_ready), 32'h0);
      tick();
      drive(0, 1, 2, 1, 6, 0, 0, 0, 0);
      chk("flush_r1", 32'(bus.rs_busy), 32'h0);
      chk("flush_r2", 32'(bus.rq_busy), 32'h0);
      tick();
      drive(0, 0, 0, 0, 0, 1, 11, 32'hb, 1); tick();
      drive(0, 11, 0, 0, 0, 0, 0, 0, 0);
      chk("flush_wr_data", bus.rs_out, 32'hb);
      chk("flush_no_err", 32'(bus.wr_err), 32'h0);
      tick();

      drive(0, 0, 0, 0, 0, 1, 12, 32'hc, 0); tick();
      drive(1, 0, 0, 1, 7, 1, 6, 32'h66, 1); tick();
      drive(0, 6, 5, 1, 6, 0, 0, 0, 0);
      chk("rst_r6", bus.rs_out, 32'h0);
      chk("rst_r5", bus.rq_out, 32'h0);
      chk("rst_busy6", 32'(bus.rs_busy), 32'h0);
      chk("rst_err", 32'(bus.wr_err), 32'h0);
      tick();

      for (int i = 0; i < 600; i++) begin
         drive(($urandom_range(63) == 0),
               5'($urandom_range(7)), 5'($urandom_range(7)),
               1'($urandom), 5'($urandom_range(7)),
               1'($urandom), 5'($urandom_range(7)),
               $urandom, ($urandom_range(15) == 0));
         tick();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/m_regfile.md
M_REGFILE -- requirements
Module: m_regfile

Interface
REQ-001 SHALL have parameter NREGS, default 32, number of architectural registers (fixed 32; selects are 5 bits).
REQ-002 SHALL have parameter WIDTH, default 32, register data width.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port rs_sel  input  5  read-port-S register select (driven by m_decoder).
REQ-006 SHALL have port rs_out  output  32  read-port-S data (feeds m_decoder rs_in).
REQ-007 SHALL have port rq_sel  input  5  read-port-Q register select (driven by m_decoder).
REQ-008 SHALL have port rq_out  output  32  read-port-Q data (feeds m_decoder rq_in).
REQ-009 SHALL have port rs_busy / rq_busy  output  1 each  selected register has a pending write.
REQ-010 SHALL have port rsv_valid  input  1  request to reserve destination register rsv_sel.
REQ-011 SHALL have port rsv_sel  input  5  destination register to reserve (decoded.rd).
REQ-012 SHALL have port rsv_ready  output  1  reservation accepted this cycle.
REQ-013 SHALL have port wr_valid  input  1  writeback request.
REQ-014 SHALL have port wr_sel  input  5  writeback register.
REQ-015 SHALL have port wr_data  input  32  writeback data.
REQ-016 SHALL have port wr_err  output  1  registered pulse: writeback to a non-reserved register.
REQ-017 SHALL have port flush  input  1  discard all pending reservations.

Function
REQ-018 Reads SHALL be combinational, zero latency: rs_out = reg[rs_sel], rq_out = reg[rq_sel].
REQ-019 Register r0 SHALL read 32'h0, discard writes, never be busy; rsv_ready SHALL be 1 for rsv_sel=0 with no state change.
REQ-020 Bypass: when wr_valid and wr_sel equals a read select (nonzero), that port SHALL output wr_data in the same cycle.
REQ-021 Writeback SHALL always be accepted (no wr_ready); reg[wr_sel] SHALL update at the next edge.
REQ-022 Scoreboard: 32-bit busy vector; rs_busy = busy[rs_sel] & ~(wr_valid & wr_sel==rs_sel); rq_busy likewise.
REQ-023 rsv_ready SHALL equal rsv_valid & ~busy[rsv_sel] & ~flush (WAW stall while pending).
REQ-024 Accepted reservation SHALL set busy[rsv_sel] at next edge.
REQ-025 wr_valid SHALL clear busy[wr_sel] at next edge.
REQ-026 Same-cycle write and reservation of the same busy register: write clears, reservation refused (rsv_ready=0); busy=0 next cycle, reservation retried.
REQ-027 Same-cycle write and reservation of different registers SHALL both take effect.
REQ-028 wr_valid with busy[wr_sel]=0 and wr_sel!=0: data SHALL still be written; wr_err SHALL be 1 the following cycle for exactly one cycle.
REQ-029 flush SHALL clear all busy bits at next edge; a write in the same cycle SHALL still update data, with no wr_err.

Reset
REQ-030 rst SHALL zero all registers, busy vector and wr_err at the next edge; rst overrides wr_valid, rsv_valid and flush.
REQ-031 After reset: rs_out=rq_out=0, rs_busy=rq_busy=0, rsv_ready=rsv_valid.

Structure
REQ-032 Register-index type (5 bits), WIDTH, NREGS SHALL live in the shared core package alongside s_decoded.
REQ-033 The scoreboard SHALL be the sub-module m_scoreboard (busy vector, rsv_ready, wr_err); storage and bypass stay in m_regfile.

Verification
REQ-034 Reset, write r5=32'haaaaaaaa, next cycle rs_sel=5 -> rs_out=32'haaaaaaaa; rq_sel=0 -> rq_out=0.
REQ-035 wr r7=32'hffffffff with rq_sel=7 same cycle -> rq_out=32'hffffffff combinationally.
REQ-036 Reserve r3 -> rsv_ready=1, next cycle rs_sel=3 gives rs_busy=1; re-reserve r3 -> rsv_ready=0; write r3 -> busy clears next cycle.
REQ-037 Reserve r4 busy + wr r4 same cycle -> rsv_ready=0, busy[4]=0 next cycle; retry -> rsv_ready=1.
REQ-038 Write r9 unreserved -> wr_err=1 one cycle later for one cycle, reg[9] updated; write r0=32'h1234 -> r0 reads 0, no wr_err.
REQ-039 Reserve r1,r2, assert flush with rsv_valid r6 -> rsv_ready=0, all busy cleared; rst mid-sequence -> all outputs at reset values next cycle.
